// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory handshake and IF/ID payload.
interface fetch_if #(
    parameter int unsigned N = 32
);
    logic         freeze;
    logic         branch_taken;
    logic [N-1:0] branch_addr;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ready;
    logic [N-1:0] imem_data;
    logic [N-1:0] pc_out;
    logic [N-1:0] instruction;
    logic         inst_valid;
    logic         fetch_busy;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_ready, imem_data,
        output imem_req, imem_addr, pc_out, instruction, inst_valid, fetch_busy
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_ready, imem_data,
        input  imem_req, imem_addr, pc_out, instruction, inst_valid, fetch_busy
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handles memory wait states, stall holding and
// branch redirects, and presents a bubble whenever no instruction is available.
module if_fetch_unit #(
    parameter int unsigned     N        = 32,
    parameter logic [N-1:0]    RESET_PC = '0,
    parameter logic [N-1:0]    PC_STEP  = N'(4)
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.master bus
);
    typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_DROP} state_t;

    state_t       state, state_nxt;
    logic [N-1:0] pc, pc_nxt;
    logic [N-1:0] drop_addr, drop_addr_nxt;
    logic [N-1:0] hold_pc, hold_pc_nxt;
    logic [N-1:0] hold_inst, hold_inst_nxt;
    logic [N-1:0] pc_inc;

    logic         req;
    logic [N-1:0] addr;
    logic [N-1:0] out_pc;
    logic [N-1:0] out_inst;
    logic         out_valid;

    assign pc_inc = pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            drop_addr <= '0;
            hold_pc   <= '0;
            hold_inst <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            drop_addr <= drop_addr_nxt;
            hold_pc   <= hold_pc_nxt;
            hold_inst <= hold_inst_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_addr_nxt = drop_addr;
        hold_pc_nxt   = hold_pc;
        hold_inst_nxt = hold_inst;
        req           = 1'b0;
        addr          = pc;
        out_pc        = '0;
        out_inst      = '0;
        out_valid     = 1'b0;

        unique case (state)
            ST_FETCH: begin
                req  = 1'b1;
                addr = pc;
                if (bus.branch_taken) begin
                    pc_nxt = bus.branch_addr;
                    // The outstanding request must still complete before refetching.
                    if (!bus.imem_ready) begin
                        drop_addr_nxt = pc;
                        state_nxt     = ST_DROP;
                    end
                end else if (bus.imem_ready) begin
                    out_pc    = pc_inc;
                    out_inst  = bus.imem_data;
                    out_valid = 1'b1;
                    pc_nxt    = pc_inc;
                    if (bus.freeze) begin
                        hold_inst_nxt = bus.imem_data;
                        hold_pc_nxt   = pc_inc;
                        state_nxt     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                out_pc    = hold_pc;
                out_inst  = hold_inst;
                out_valid = 1'b1;
                if (bus.branch_taken) begin
                    pc_nxt    = bus.branch_addr;
                    state_nxt = ST_FETCH;
                end else if (!bus.freeze) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_DROP: begin
                req  = 1'b1;
                addr = drop_addr;
                if (bus.branch_taken) begin
                    pc_nxt = bus.branch_addr;
                end
                if (bus.imem_ready) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase

        if (rst) begin
            req       = 1'b0;
            out_pc    = '0;
            out_inst  = '0;
            out_valid = 1'b0;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = addr;
    assign bus.pc_out      = out_pc;
    assign bus.instruction = out_inst;
    assign bus.inst_valid  = out_valid;
    assign bus.fetch_busy  = (state != ST_FETCH) | ~bus.imem_ready;
endmodule
